// File: rtl/paddsb_iter.sv
`default_nettype none
// ============================================================================
//  Module      : paddsb_iter
//  Description : Multi-cycle packed saturating add/subtract unit. Processes
//                one signed lane per cycle behind a start/done handshake.
//                Operands are latched on an accepted start; the result and
//                per-lane saturation flags hold until lanes are rewritten by
//                the next operation.
//  Ports       : clk   - system clock, all state on rising edge
//                rst   - synchronous active-high reset
//                start - request, sampled only in IDLE or DONE
//                sub   - 0: rd = rs + rt, 1: rd = rs - rt (per lane)
//                rs    - operand A, packed lanes, lane 0 in the low bits
//                rt    - operand B, same packing
//                busy  - high while lanes are being computed
//                done  - one-cycle pulse when rd/sat are valid
//                rd    - packed saturated result
//                sat   - bit i set when lane i saturated
//  Revision    : 1.0 - initial release
// ============================================================================
module paddsb_iter #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sub,
    input  logic [LANES*LANE_W-1:0]   rs,
    input  logic [LANES*LANE_W-1:0]   rt,
    output logic                      busy,
    output logic                      done,
    output logic [LANES*LANE_W-1:0]   rd,
    output logic [LANES-1:0]          sat
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(LANES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_rs;
    logic [DATA_W-1:0] r_rt;
    logic              r_sub;
    logic [DATA_W-1:0] r_rd;
    logic [LANES-1:0]  r_sat;

    logic              w_accept;
    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_b;
    logic [LANE_W:0]   w_ea;
    logic [LANE_W:0]   w_eb;
    logic [LANE_W:0]   w_res;
    logic [LANE_W-1:0] w_lane;
    logic              w_sat;

    // A new request is only taken when not computing.
    assign w_accept = start && ((r_state == c_st_idle) || (r_state == c_st_done));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (start) w_next_state = c_st_calc;
            c_st_calc: if (r_idx == c_last_idx) w_next_state = c_st_done;
            c_st_done: w_next_state = start ? c_st_calc : c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs; busy and done are mutually exclusive by
    // construction since they decode different states.
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state == c_st_calc);
        done = (r_state == c_st_done);
    end

    // ------------------------------------------------------------------
    // Lane datapath. Both lanes are sign-extended by one bit so that the
    // sum or difference never wraps (e.g. 7 - (-8) = 15 still fits).
    // Overflow of the LANE_W-bit range shows up as the two top bits of the
    // extended result differing; the top bit then gives the direction.
    // ------------------------------------------------------------------
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a = r_rs[i*LANE_W +: LANE_W];
                w_b = r_rt[i*LANE_W +: LANE_W];
            end
        end
        w_ea  = {w_a[LANE_W-1], w_a};
        w_eb  = {w_b[LANE_W-1], w_b};
        w_res = r_sub ? (w_ea - w_eb) : (w_ea + w_eb);
        if (w_res[LANE_W] != w_res[LANE_W-1]) begin
            w_sat  = 1'b1;
            w_lane = w_res[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                   : {1'b0, {(LANE_W-1){1'b1}}};
        end else begin
            w_sat  = 1'b0;
            w_lane = w_res[LANE_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Operand latch, lane index and result registers. Result lanes are
    // overwritten one at a time and never bulk-cleared on a new start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_rs  <= '0;
            r_rt  <= '0;
            r_sub <= 1'b0;
            r_rd  <= '0;
            r_sat <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
            r_rs  <= rs;
            r_rt  <= rt;
            r_sub <= sub;
        end else if (r_state == c_st_calc) begin
            for (int i = 0; i < LANES; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_rd[i*LANE_W +: LANE_W] <= w_lane;
                    r_sat[i]                 <= w_sat;
                end
            end
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign rd  = r_rd;
    assign sat = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_paddsb_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddsb_iter
//  Description : Self-checking bench for paddsb_iter: directed add/subtract
//                vectors, handshake latency, back-to-back starts, reset in
//                the middle of an operation and a random reference compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddsb_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] rs;
    logic [15:0] rt;
    logic        busy;
    logic        done;
    logic [15:0] rd;
    logic [3:0]  sat;

    int n_cmp     = 0;
    int n_err     = 0;
    int n_overlap = 0;

    paddsb_iter #(.LANES(4), .LANE_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .done  (done),
        .rd    (rd),
        .sat   (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: per-lane integer result clamped to [-8, 7].
    function automatic logic [19:0] ref_op(input logic s, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  f;
        int x, y, z;
        r = '0;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            x = int'($signed(a[i*4 +: 4]));
            y = int'($signed(b[i*4 +: 4]));
            z = s ? (x - y) : (x + y);
            if (z > 7) begin
                r[i*4 +: 4] = 4'h7;
                f[i]        = 1'b1;
            end else if (z < -8) begin
                r[i*4 +: 4] = 4'h8;
                f[i]        = 1'b1;
            end else begin
                r[i*4 +: 4] = z[3:0];
                f[i]        = 1'b0;
            end
        end
        return {f, r};
    endfunction

    // One start pulse; returns at the negedge where done is seen (or bound hit).
    // lat counts cycles after the sampling edge; nbusy counts busy cycles.
    task automatic do_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    logic [15:0] v_rs  [5] = '{16'h2456, 16'h8888, 16'h7000, 16'h8888, 16'h1234};
    logic [15:0] v_rt  [5] = '{16'h4731, 16'h8888, 16'h8123, 16'h1111, 16'h1234};
    logic        v_sub [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] v_rd  [5] = '{16'h6777, 16'h8888, 16'h7FED, 16'h8888, 16'h0000};
    logic [3:0]  v_sat [5] = '{4'b0110, 4'b1111, 4'b1000, 4'b1111, 4'b0000};

    initial begin
        int lat;
        int nb;
        int ndone;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [19:0] exp_v;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        rs    = '0;
        rt    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd",   32'(rd),   32'd0);
        check("rst_sat",  32'(sat),  32'd0);
        rst = 1'b0;

        // Directed vectors
        for (int k = 0; k < 5; k++) begin
            do_op(v_sub[k], v_rs[k], v_rt[k], lat, nb);
            check("dir_lat",  32'(lat), 32'd5);
            check("dir_busy", 32'(nb),  32'd4);
            check("dir_rd",   32'(rd),  32'(v_rd[k]));
            check("dir_sat",  32'(sat), 32'(v_sat[k]));
            @(negedge clk);
            check("dir_idle_busy", 32'(busy), 32'd0);
            check("dir_idle_done", 32'(done), 32'd0);
        end

        // start held high and operands scrambled during CALC
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b1;
        rs    = 16'h7000;
        rt    = 16'h8123;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            rs  = 16'($urandom);
            rt  = 16'($urandom);
            sub = ~sub;
        end while (!done && lat < 20);
        start = 1'b0;
        check("hold_lat", 32'(lat), 32'd5);
        check("hold_rd",  32'(rd),  32'h7FED);
        check("hold_sat", 32'(sat), 32'h8);
        @(negedge clk);
        check("hold_idle", 32'(busy), 32'd0);

        // Back-to-back: restart in the DONE cycle
        do_op(1'b0, 16'h2456, 16'h4731, lat, nb);
        check("b2b_first_rd",  32'(rd),  32'h6777);
        check("b2b_first_sat", 32'(sat), 32'h6);
        start = 1'b1;
        sub   = 1'b1;
        rs    = 16'h1234;
        rt    = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat", 32'(lat), 32'd5);
        check("b2b_rd",  32'(rd),  32'h0000);
        check("b2b_sat", 32'(sat), 32'h0);

        // Reset during the second CALC cycle
        do_op(1'b0, 16'h8888, 16'h8888, lat, nb);
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b0;
        rs    = 16'h2456;
        rt    = 16'h4731;
        @(negedge clk);
        start = 1'b0;
        check("mid_busy_pre", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_rd",   32'(rd),   32'd0);
        check("mid_sat",  32'(sat),  32'd0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_no_done", 32'(ndone), 32'd0);
        do_op(1'b1, 16'h8888, 16'h1111, lat, nb);
        check("mid_after_lat", 32'(lat), 32'd5);
        check("mid_after_rd",  32'(rd),  32'h8888);
        check("mid_after_sat", 32'(sat), 32'hF);

        // Random compare against the clamp model
        for (int k = 0; k < 1000; k++) begin
            a     = 16'($urandom);
            b     = 16'($urandom);
            s     = 1'($urandom);
            exp_v = ref_op(s, a, b);
            do_op(s, a, b, lat, nb);
            check("rnd_lat", 32'(lat), 32'd5);
            check("rnd_rd",  32'(rd),  32'(exp_v[15:0]));
            check("rnd_sat", 32'(sat), 32'(exp_v[19:16]));
        end

        check("busy_done_overlap", 32'(n_overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
